truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
Sequential exhaustive tester for small combinational function implementations, such as a NAND-only realisation checked against its boolean expression.
- Drives every input vector onto two function instances (reference and candidate).
- Waits for settle, samples both outputs and compares them.
- Reports pass/fail, mismatch count and the first failing vector.
- Synthesizable; sits between a start strobe (bench or board switch) and the pair of 1-bit function outputs.

Parameters:
N_IN, 2, number of function inputs; vectors 0 .. 2^N_IN-1.
SETTLE_CYCLES, 1, cycles vector is held before sampling; legal range >=1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
vec_out  output  N_IN  current input vector to both function instances; bit N_IN-1 = first operand (a), bit 0 = last (b).
ref_in  input  1  output of reference implementation.
dut_in  input  1  output of candidate implementation.
busy  output  1  high in SETTLE/COMPARE.
done  output  1  high while in DONE.
pass  output  1  valid when done; 1 iff err_count==0.
err_count  output  N_IN+1  number of mismatching vectors; max 2^N_IN, no overflow possible.
first_err_valid  output  1  at least one mismatch recorded this sweep.
first_err_vec  output  N_IN  vector of first mismatch; 0 when first_err_valid=0.

Behaviour:
- Reset (reset=1 at an edge, any state, including mid-sweep):
  - State becomes IDLE.
  - vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec all 0.
  - Settle counter and vector index cleared.
  - Reset has priority over start.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE, start=1: next edge -> SETTLE, idx=0, vec_out=0, err_count=0, first_err_valid=0, first_err_vec=0, busy=1.
- SETTLE: lasts exactly SETTLE_CYCLES cycles with vec_out=idx held, then -> COMPARE.
- COMPARE: one cycle. At its ending edge, ref_in and dut_in are sampled.
  - If ref_in!=dut_in: err_count+=1.
  - If also first_err_valid=0: first_err_vec=idx, first_err_valid=1.
  - If idx==2^N_IN-1: -> DONE, busy=0, done=1, pass=(final err_count==0). Final err_count includes the current sample.
  - Else: idx+=1, vec_out=idx+1, -> SETTLE.
- Per-vector cost: SETTLE_CYCLES+1 cycles. Total sweep: 2^N_IN*(SETTLE_CYCLES+1) cycles from the start edge to done rising.
  - Example: N_IN=2, SETTLE_CYCLES=1 gives 8 cycles.
- DONE: results held stable; vec_out holds last vector. start=1 restarts exactly as from IDLE; done/pass drop on that edge.
- start while busy: ignored, no restart, no effect on results.
- X/Z on ref_in or dut_in is not handled; the bench guarantees 0/1.

Decomposition:
- Shared include/package: state encoding localparams (S_IDLE=0, S_SETTLE=1, S_COMPARE=2, S_DONE=3) and default N_IN/SETTLE_CYCLES.
- One natural sub-module: settle_timer.
  - Loadable down-counter; load on SETTLE entry.
  - Asserts expire on the last SETTLE cycle.
  - Width clog2(SETTLE_CYCLES+1).
- Index register, compare/accumulate logic and FSM stay in the top module.

Test Plan:
1. N_IN=2, SETTLE=1, dut_in=ref_in=~(a&~b) (1,1,0,1 for vectors 00,01,10,11); pulse start -> busy 8 cycles; vec_out 00,00,01,01,10,10,11,11; done=1, pass=1, err_count=0, first_err_valid=0.
2. Candidate outputs constant 1, reference ~(a&~b) -> mismatch only at vector 10; done at cycle 8; err_count=1, first_err_vec=2'b10, pass=0.
3. Candidate = ~reference -> err_count=4, first_err_vec=2'b00, pass=0; second start from DONE clears results and, with a fixed candidate, yields pass=1, err_count=0.
4. start held high throughout the sweep -> sweep not restarted; done still at cycle 8 with the same results as scenario 1; next edge in DONE with start=1 begins a new sweep.
5. reset asserted for one cycle while idx=2 (in SETTLE) -> next cycle all outputs 0 and state IDLE; later start gives a full clean 8-cycle sweep.
6. N_IN=3, SETTLE_CYCLES=3, reference a^b^c, candidate a|b|c -> done 32 cycles after start; err_count=3 (vectors 011,101,110), first_err_vec=3'b011.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared state encoding and default sizing for the
// exhaustive truth-table checker.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 2;
  localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that flags the last cycle a
// vector is held before sampling.
module truth_table_checker_settle_timer #(
  parameter int SETTLE_CYCLES = 1,
  localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector over a reference/candidate
// pair and records mismatch count and first failure.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            ref_in,
  input  logic            dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fev_q, fev_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_expire;

  // Reload on every entry into SETTLE, from IDLE/DONE or COMPARE.
  assign tmr_load = (state_d == S_SETTLE) && (state_q != S_SETTLE);
  assign tmr_en   = (state_q == S_SETTLE);

  truth_table_checker_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = '0;
        end
      end
      S_SETTLE: begin
        if (tmr_expire) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (ref_in != dut_in) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fev_q) begin
            fev_d  = 1'b1;
            fvec_d = idx_q;
          end
        end
        if (idx_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  assign vec_out         = idx_q;
  assign busy            = (state_q == S_SETTLE) || (state_q == S_COMPARE);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a sweep-level
// reference model checked every cycle.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  int         mode_a = 0;

  logic [1:0] vec_a;
  logic       ref_a, dut_a, busy_a, done_a, pass_a, fev_a;
  logic [2:0] err_a;
  logic [1:0] fvec_a;

  logic [2:0] vec_b;
  logic       ref_b, dut_b, busy_b, done_b, pass_b, fev_b;
  logic [3:0] err_b;
  logic [2:0] fvec_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Function pairs under test: returns {reference, candidate}.
  function automatic logic [1:0] fpair(int md, int v);
    logic [2:0] vv;
    logic a, b, c, r, d;
    vv = 3'(v);
    r = 1'b0;
    d = 1'b0;
    if (md == 3) begin
      a = vv[2]; b = vv[1]; c = vv[0];
      r = a ^ b ^ c;
      d = a | b | c;
    end else begin
      a = vv[1]; b = vv[0];
      r = ~(a & ~b);
      d = (md == 0) ? r : (md == 1) ? 1'b1 : ~r;
    end
    return {r, d};
  endfunction

  assign {ref_a, dut_a} = fpair(mode_a, int'(vec_a));
  assign {ref_b, dut_b} = fpair(3, int'(vec_b));

  truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .vec_out(vec_a),
    .ref_in(ref_a), .dut_in(dut_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a),
    .first_err_vec(fvec_a)
  );

  truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .vec_out(vec_b),
    .ref_in(ref_b), .dut_in(dut_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_valid(fev_b),
    .first_err_vec(fvec_b)
  );

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Mismatch statistics over the first c vectors of a function pair.
  task automatic exp_res(int md, int c, output int cnt,
                         output int fvv, output int fv);
    logic [1:0] p;
    cnt = 0; fvv = 0; fv = 0;
    for (int v = 0; v < c; v++) begin
      p = fpair(md, v);
      if (p[1] != p[0]) begin
        if (cnt == 0) begin
          fv = 1;
          fvv = v;
        end
        cnt++;
      end
    end
  endtask

  // Model phase: 0 idle, 1 sweeping (k edges since start), 2 done.
  bit armed = 0;
  int ph_a = 0, k_a = 0, md_a = 0;
  int ph_b = 0, k_b = 0, md_b = 3;

  task automatic step(inout int ph, inout int k, inout int md,
                      input logic st, input int mode, input int tot);
    if (ph == 1) begin
      k++;
      if (k == tot) ph = 2;
    end else if (st) begin
      ph = 1;
      k = 0;
      md = mode;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      armed = 1;
      ph_a = 0; k_a = 0;
      ph_b = 0; k_b = 0;
    end else begin
      step(ph_a, k_a, md_a, start_a, mode_a, 4 * 2);
      step(ph_b, k_b, md_b, start_b, 3, 8 * 4);
    end
  end

  task automatic cmp(string t, int n, int s, int ph, int k, int md,
                     int vec, int busy, int done, int pass,
                     int err, int fev, int fvec);
    int ev, c, eb, ed, cnt, fvv, fv;
    ev = 0; c = 0; eb = 0; ed = 0;
    if (ph == 1) begin
      ev = k / (s + 1);
      c = ev;
      eb = 1;
    end else if (ph == 2) begin
      ev = (1 << n) - 1;
      c = 1 << n;
      ed = 1;
    end
    exp_res(md, c, cnt, fvv, fv);
    chk({t, "_vec"}, vec, ev);
    chk({t, "_busy"}, busy, eb);
    chk({t, "_done"}, done, ed);
    chk({t, "_pass"}, pass, (ed == 1 && cnt == 0) ? 1 : 0);
    chk({t, "_err"}, err, cnt);
    chk({t, "_fev"}, fev, fv);
    chk({t, "_fvec"}, fvec, fvv);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("a", 2, 1, ph_a, k_a, md_a, int'(vec_a), int'(busy_a),
          int'(done_a), int'(pass_a), int'(err_a), int'(fev_a),
          int'(fvec_a));
      cmp("b", 3, 3, ph_b, k_b, md_b, int'(vec_b), int'(busy_b),
          int'(done_b), int'(pass_b), int'(err_b), int'(fev_b),
          int'(fvec_b));
    end
  end

  task automatic wait_a(output int n);
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_a(input int md, output int n);
    mode_a = md;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_a(n);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);

    run_a(0, n);
    chk("s1_lat", n, 8);
    chk("s1_pass", int'(pass_a), 1);
    chk("s1_err", int'(err_a), 0);
    chk("s1_fev", int'(fev_a), 0);

    run_a(1, n);
    chk("s2_lat", n, 8);
    chk("s2_err", int'(err_a), 1);
    chk("s2_fvec", int'(fvec_a), 2);
    chk("s2_pass", int'(pass_a), 0);

    run_a(2, n);
    chk("s3_err", int'(err_a), 4);
    chk("s3_fvec", int'(fvec_a), 0);
    chk("s3_pass", int'(pass_a), 0);
    run_a(0, n);
    chk("s3b_lat", n, 8);
    chk("s3b_pass", int'(pass_a), 1);
    chk("s3b_err", int'(err_a), 0);

    mode_a = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk);
    wait_a(n);
    chk("s4_lat", n, 8);
    chk("s4_pass", int'(pass_a), 1);
    @(negedge clk);
    chk("s4_restart_busy", int'(busy_a), 1);
    chk("s4_restart_done", int'(done_a), 0);
    start_a = 1'b0;
    wait_a(n);
    chk("s4b_lat", n, 8);

    mode_a = 2;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_vec_mid", int'(vec_a), 2);
    chk("s5_err_mid", int'(err_a), 2);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("s5_vec", int'(vec_a), 0);
    chk("s5_busy", int'(busy_a), 0);
    chk("s5_err", int'(err_a), 0);
    chk("s5_fev", int'(fev_a), 0);
    run_a(0, n);
    chk("s5_lat", n, 8);
    chk("s5_pass", int'(pass_a), 1);

    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s6_lat", n, 32);
    chk("s6_err", int'(err_b), 3);
    chk("s6_fvec", int'(fvec_b), 3);
    chk("s6_pass", int'(pass_b), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
